piso_stream: RTL and testbench

PISO_STREAM -- requirements
Module: piso_stream

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_skid_reg.sv | 41 ++++
 rtl/piso_stream.sv | 137 +++++++++++++
 tb/tb_piso_stream.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared FSM state type and counter-width helper for piso_stream.
// The PARITY state only exists when PISO_STREAM_PARITY_EN is defined.
package piso_pkg;

`ifdef PISO_STREAM_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   function automatic int beat_cnt_w(input int beats);
      return $clog2(beats + 1);
   endfunction

endpackage

// File: rtl/piso_skid_reg.sv
// One-word hold register with full flag; a loaded word is visible the next cycle.
// Backpressure: rdy = not full, held low until the first clock after reset; load beats unload.
module piso_skid_reg #(
   parameter int WIDTH = 9
) (
   input  logic             clk_i,
   input  logic             a_rst_n_i,
   input  logic             load_vld,
   input  logic             unload,
   input  logic [WIDTH-1:0] in_dat,
   output logic [WIDTH-1:0] out_dat,
   output logic             full,
   output logic             rdy
);

   logic [WIDTH-1:0] dat_q;
   logic             full_q;
   logic             live_q;

   always_ff @(posedge clk_i or negedge a_rst_n_i) begin
      if (!a_rst_n_i) begin
         dat_q  <= '0;
         full_q <= 1'b0;
         live_q <= 1'b0;
      end else begin
         live_q <= 1'b1;
         // A load in the same cycle as an unload leaves the new word resident.
         if (load_vld) begin
            dat_q  <= in_dat;
            full_q <= 1'b1;
         end else if (unload) begin
            full_q <= 1'b0;
         end
      end
   end

   assign out_dat = dat_q;
   assign full    = full_q;
   assign rdy     = live_q & ~full_q;

endmodule

// File: rtl/piso_stream.sv
// Parallel-to-serial framer, LANES bits per en_i beat; first beat one cycle after accept, optional parity beat (PISO_STREAM_PARITY_EN).
// Backpressure: s_ready_o drops while the hold register is full; frames run back-to-back from hold or bypass.
module piso_stream
   import piso_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 1
) (
   input  logic                  clk_i,
   input  logic                  a_rst_n_i,
   input  logic                  en_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   input  logic                  msb_first_i,
   output logic [LANES-1:0]      data_o,
   output logic                  valid_o,
   output logic                  sof_o,
   output logic                  eof_o
);

   localparam int BEATS = DATA_WIDTH / LANES;
   localparam int CNT_W = beat_cnt_w(BEATS);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  msb_q, msb_d;
   logic [CNT_W-1:0]      beat_q, beat_d;
   logic                  hold_full, hold_load, hold_unload;
   logic [DATA_WIDTH:0]   hold_dat;
   logic                  accept, last_beat, frame_end, start;
   logic [DATA_WIDTH-1:0] nxt_word;
   logic                  nxt_msb;
`ifdef PISO_STREAM_PARITY_EN
   logic                  par_q, par_d;
`endif

   assign accept    = s_valid_i & s_ready_o;
   assign last_beat = (state_q == SHIFT) && (beat_q == CNT_W'(BEATS - 1));
`ifdef PISO_STREAM_PARITY_EN
   assign frame_end = en_i && (state_q == PARITY);
`else
   assign frame_end = en_i && last_beat;
`endif

   // Next frame source: hold word first, then a same-cycle arrival, else go idle.
   assign start       = ((state_q == IDLE) && accept) || (frame_end && (hold_full || accept));
   assign hold_unload = frame_end && hold_full;
   assign hold_load   = accept && (state_q != IDLE) && !(frame_end && !hold_full);
   assign nxt_word    = hold_full ? hold_dat[DATA_WIDTH-1:0] : s_data_i;
   assign nxt_msb     = hold_full ? hold_dat[DATA_WIDTH] : msb_first_i;

   piso_skid_reg #(
      .WIDTH (DATA_WIDTH + 1)
   ) u_hold (
      .clk_i     (clk_i),
      .a_rst_n_i (a_rst_n_i),
      .load_vld  (hold_load),
      .unload    (hold_unload),
      .in_dat    ({msb_first_i, s_data_i}),
      .out_dat   (hold_dat),
      .full      (hold_full),
      .rdy       (s_ready_o)
   );

   always_ff @(posedge clk_i or negedge a_rst_n_i) begin
      if (!a_rst_n_i) begin
         state_q <= IDLE;
         shift_q <= '0;
         msb_q   <= 1'b0;
         beat_q  <= '0;
`ifdef PISO_STREAM_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         msb_q   <= msb_d;
         beat_q  <= beat_d;
`ifdef PISO_STREAM_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      msb_d   = msb_q;
      beat_d  = beat_q;
`ifdef PISO_STREAM_PARITY_EN
      par_d   = par_q;
`endif
      data_o  = '0;
      valid_o = 1'b0;
      sof_o   = 1'b0;
      eof_o   = 1'b0;

      if (start) begin
         state_d = SHIFT;
         shift_d = nxt_word;
         msb_d   = nxt_msb;
         beat_d  = '0;
`ifdef PISO_STREAM_PARITY_EN
         par_d   = ^nxt_word;
`endif
      end else if (frame_end) begin
         state_d = IDLE;
         shift_d = '0;
         beat_d  = '0;
`ifdef PISO_STREAM_PARITY_EN
      end else if (en_i && last_beat) begin
         state_d = PARITY;
`endif
      end else if (en_i && (state_q == SHIFT)) begin
         shift_d = msb_q ? (shift_q << LANES) : (shift_q >> LANES);
         beat_d  = beat_q + CNT_W'(1);
      end

      if (state_q == SHIFT) begin
         valid_o = 1'b1;
         data_o  = msb_q ? shift_q[DATA_WIDTH-1 -: LANES] : shift_q[LANES-1:0];
         sof_o   = (beat_q == '0);
`ifndef PISO_STREAM_PARITY_EN
         eof_o   = last_beat;
`endif
      end
`ifdef PISO_STREAM_PARITY_EN
      if (state_q == PARITY) begin
         valid_o           = 1'b1;
         data_o[LANES-1]   = par_q;
         eof_o             = 1'b1;
      end
`endif
   end

endmodule

// File: tb/tb_piso_stream.sv
// Directed bench for piso_stream: a frame/queue model checked every cycle on u0,
// plus literal beat sequences on both a 1-lane (u0) and a 2-lane (u1) instance.
module tb_piso_stream;

   localparam int DW = 8;
   localparam int L0 = 1;
   localparam int L1 = 2;
   localparam int B0 = DW / L0;
   localparam int B1 = DW / L1;
`ifdef PISO_STREAM_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int LAST0 = B0 - 1 + PAR;
   localparam int F0    = B0 + PAR;
   localparam int F1    = B1 + PAR;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          v0 = 1'b0, m0 = 1'b1, v1 = 1'b0, m1 = 1'b0;
   logic [DW-1:0] d0 = '0, d1 = '0;
   logic          r0, va0, sof0, eof0, r1, va1, sof1, eof1;
   logic [L0-1:0] q0;
   logic [L1-1:0] q1;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [2:0] log0[$];
   int         st0[$];
   logic [3:0] log1[$];

   bit         exp_a5[8]  = '{1, 0, 1, 0, 0, 1, 0, 1};
   bit         exp_3c[8]  = '{0, 0, 1, 1, 1, 1, 0, 0};
   bit         exp_07[8]  = '{0, 0, 0, 0, 0, 1, 1, 1};
   bit         exp_seq[16] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
   logic [1:0] exp_1b[4]  = '{2'b11, 2'b10, 2'b01, 2'b00};

   // Model state: the word being serialised, its beat index, and words waiting behind it.
   logic [DW-1:0] m_word = '0;
   logic          m_msb = 1'b0;
   bit            m_act = 1'b0;
   bit            m_live = 1'b0;
   int            m_k = 0;
   logic [DW:0]   m_q[$];

   always #5 clk = ~clk;

   piso_stream #(.DATA_WIDTH(DW), .LANES(L0)) u0 (
      .clk_i(clk), .a_rst_n_i(rst_n), .en_i(en), .s_valid_i(v0), .s_ready_o(r0),
      .s_data_i(d0), .msb_first_i(m0), .data_o(q0), .valid_o(va0), .sof_o(sof0), .eof_o(eof0)
   );

   piso_stream #(.DATA_WIDTH(DW), .LANES(L1)) u1 (
      .clk_i(clk), .a_rst_n_i(rst_n), .en_i(en), .s_valid_i(v1), .s_ready_o(r1),
      .s_data_i(d1), .msb_first_i(m1), .data_o(q1), .valid_o(va1), .sof_o(sof1), .eof_o(eof1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
      end
   endtask

   function automatic logic exp_bit(input logic [DW-1:0] w, input logic msb, input int k);
      if (k >= B0) return ^w;
      return msb ? w[DW-1-k] : w[k];
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_act = 1'b0;
            m_live = 1'b0;
            m_k = 0;
            m_q.delete();
         end else begin : step
            bit acc, ending;
            acc    = v0 && m_live && (m_q.size() == 0);
            ending = m_act && en && (m_k == LAST0);
            if (acc && m_act && !ending) m_q.push_back({m0, d0});
            if (!m_act || ending) begin
               if (ending && m_q.size() > 0) begin
                  {m_msb, m_word} = m_q.pop_front();
                  m_k = 0;
               end else if (acc) begin
                  m_act = 1'b1;
                  m_word = d0;
                  m_msb = m0;
                  m_k = 0;
               end else begin
                  m_act = 1'b0;
               end
            end else if (en) begin
               m_k++;
            end
            m_live = 1'b1;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         chk("valid_o", va0, m_act);
         chk("data_o", q0, m_act ? exp_bit(m_word, m_msb, m_k) : 1'b0);
         chk("sof_o", sof0, m_act && (m_k == 0));
         chk("eof_o", eof0, m_act && (m_k == LAST0));
         chk("s_ready_o", r0, m_live && (m_q.size() == 0));
         if (en && va0) begin
            log0.push_back({eof0, sof0, q0});
            st0.push_back(cyc);
         end
         if (en && va1) log1.push_back({eof1, sof1, q1});
      end
   end

   task automatic send(input int which, input logic [DW-1:0] w, input logic msb);
      bit ok = 1'b0;
      int n = 0;
      if (which == 0) begin v0 = 1'b1; d0 = w; m0 = msb; end
      else begin v1 = 1'b1; d1 = w; m1 = msb; end
      while (!ok && n < 100) begin
         @(negedge clk);
         ok = (which == 0) ? r0 : r1;
         @(posedge clk);
         #1;
         n++;
      end
      if (which == 0) v0 = 1'b0;
      else v1 = 1'b0;
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout word %0h: got no s_ready_o, want handshake", w);
      end
   endtask

   task automatic wait_log(input int which, input int n);
      int c = 0;
      while ((((which == 0) ? log0.size() : log1.size()) < n) && c < 300) begin
         @(posedge clk);
         #1;
         c++;
      end
      if (c >= 300) begin
         n_vec++;
         n_err++;
         $display("FAIL beat_timeout: got fewer than %0d beats, want %0d", n, n);
      end
   endtask

   task automatic settle();
      repeat (3) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", va0, 0);
      chk("rst_data", q0, 0);
      chk("rst_sof", sof0, 0);
      chk("rst_eof", eof0, 0);
      chk("rst_ready", r0, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_rst", r0, 1);
      en = 1'b1;

      // 0xA5 MSB first, one bit per beat
      log0.delete(); st0.delete();
      send(0, 8'hA5, 1'b1);
      wait_log(0, F0);
      settle();
      chk("a5_len", log0.size(), F0);
      for (int i = 0; i < 8; i++) chk("a5_data", log0[i][0], exp_a5[i]);
      for (int i = 0; i < F0; i++) begin
         chk("a5_sof", log0[i][1], i == 0);
         chk("a5_eof", log0[i][2], i == LAST0);
      end

      // 0x1B LSB first, two lanes
      log1.delete();
      send(1, 8'h1B, 1'b0);
      wait_log(1, F1);
      settle();
      for (int i = 0; i < 4; i++) begin
         chk("1b_data", log1[i][1:0], exp_1b[i]);
         chk("1b_sof", log1[i][2], i == 0);
      end

      // back-to-back 0x0F, 0xF0
      log0.delete(); st0.delete();
      send(0, 8'h0F, 1'b1);
      send(0, 8'hF0, 1'b1);
      @(negedge clk);
      chk("b2b_ready_low", r0, 0);
      wait_log(0, 2 * F0);
      settle();
      chk("b2b_len", log0.size(), 2 * F0);
      chk("b2b_contig", st0[2*F0-1] - st0[0], 2 * F0 - 1);
      chk("b2b_eof1", log0[F0-1][2], 1);
      chk("b2b_sof2", log0[F0][1], 1);
      chk("b2b_sof_gap", st0[F0] - st0[F0-1], 1);
      for (int i = 0; i < 16; i++) chk("b2b_data", log0[i + ((i >= 8) ? PAR : 0)][0], exp_seq[i]);

      // en 1-on/2-off
      log0.delete(); st0.delete();
      fork
         send(0, 8'hA5, 1'b1);
         begin
            for (int c = 0; c < 60; c++) begin
               en = (c % 3 == 0);
               @(posedge clk);
               #1;
            end
         end
      join
      en = 1'b1;
      wait_log(0, F0);
      settle();
      for (int i = 0; i < 8; i++) chk("slow_data", log0[i][0], exp_a5[i]);
      for (int i = 0; i < 7; i++) chk("slow_hold3", st0[i+1] - st0[i], 3);

      // reset during beat 3
      log0.delete(); st0.delete();
      send(0, 8'hA5, 1'b1);
      wait_log(0, 3);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", va0, 0);
      chk("mid_rst_data", q0, 0);
      chk("mid_rst_sof", sof0, 0);
      chk("mid_rst_eof", eof0, 0);
      chk("mid_rst_ready", r0, 0);
      #4;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      log0.delete(); st0.delete();
      send(0, 8'h3C, 1'b1);
      wait_log(0, F0);
      settle();
      chk("3c_len", log0.size(), F0);
      chk("3c_sof", log0[0][1], 1);
      for (int i = 0; i < 8; i++) chk("3c_data", log0[i][0], exp_3c[i]);

`ifdef PISO_STREAM_PARITY_EN
      log0.delete(); st0.delete();
      send(0, 8'h07, 1'b1);
      wait_log(0, 9);
      settle();
      chk("par_len", log0.size(), 9);
      for (int i = 0; i < 8; i++) chk("par_data", log0[i][0], exp_07[i]);
      chk("par_bit", log0[8][0], 1);
      chk("par_eof", log0[8][2], 1);
      chk("par_no_early_eof", log0[7][2], 0);
`else
      if (exp_07[7] != 1'b1) $display("exp_07 table unused without parity");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
